// File: rtl/dmem_loader_pkg.sv
// Shared definitions for the data-memory loader: memory geometry, FSM encoding
// and the word-index to byte-address helper.
package dmem_loader_pkg;

    localparam int DMEM_WORDS      = 256;
    localparam int WORD_BYTES      = 4;
    localparam int WORD_ADDR_SHIFT = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } load_state_t;

    function automatic logic [31:0] word_to_byte_addr(input logic [31:0] word_idx);
        return word_idx << WORD_ADDR_SHIFT;
    endfunction

endpackage

// File: rtl/dmem_loader_if.sv
// Byte-stream input and data-memory write port of the loader.
// master = loader side, slave = byte source plus memory side.
interface dmem_loader_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        input  in_valid, in_byte,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output in_valid, in_byte,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_loader_byte_packer.sv
// Assembles four bytes little-endian into one 32-bit word; word_next already
// contains the byte being pushed so the caller can capture a full word in one edge.
module byte_packer
    import dmem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_full
);
    localparam int IDX_W = $clog2(WORD_BYTES);

    logic [IDX_W-1:0] idx_reg;
    logic [31:0]      word_reg;

    generate
        for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            assign word_next[8*gi +: 8] = (push && (idx_reg == IDX_W'(gi))) ? byte_in
                                                                           : word_reg[8*gi +: 8];
        end
    endgenerate

    assign word_full = push && (idx_reg == IDX_W'(WORD_BYTES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_reg  <= '0;
            word_reg <= '0;
        end else if (clear) begin
            idx_reg  <= '0;
            word_reg <= '0;
        end else if (push) begin
            // Index wraps naturally from 3 back to 0 on the fourth byte.
            idx_reg  <= idx_reg + IDX_W'(1);
            word_reg <= word_next;
        end
    end

endmodule

// File: rtl/dmem_loader.sv
// Streams bytes into data memory as consecutive little-endian words from
// address 0, holding the core in reset for the duration of the load.
module dmem_loader
    import dmem_loader_pkg::*;
#(
    parameter int WORDS  = DMEM_WORDS,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    dmem_loader_if.master       bus,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done,
    output logic [8:0]          word_cnt
);
    localparam int IDX_W = $clog2(WORDS);

    load_state_t       state_reg, state_next;
    logic [IDX_W-1:0]  word_idx_reg;
    logic [8:0]        word_cnt_reg;
    logic              in_ready_reg, mem_we_reg, busy_reg, done_reg, cpu_hold_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    logic        load_start;
    logic        byte_push;
    logic        word_full;
    logic        last_word;
    logic [31:0] word_next;

    // in_ready_reg is only ever high in COLLECT, so it doubles as the state qualifier.
    assign byte_push = bus.in_valid && in_ready_reg && !abort;
    assign last_word = (word_idx_reg == IDX_W'(WORDS - 1));

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (load_start || abort),
        .push      (byte_push),
        .byte_in   (bus.in_byte),
        .word_next (word_next),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        load_start = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_COLLECT;
                    load_start = 1'b1;
                end
            end
            ST_COLLECT: if (word_full) state_next = ST_WRITE;
            ST_WRITE:   state_next = last_word ? ST_DONE : ST_COLLECT;
            default:    state_next = ST_IDLE;
        endcase
        if (abort) begin
            state_next = ST_IDLE;
            load_start = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_reg  <= 1'b0;
            mem_we_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            cpu_hold_reg  <= 1'b0;
            done_reg      <= 1'b0;
            word_idx_reg  <= '0;
            word_cnt_reg  <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            in_ready_reg <= (state_next == ST_COLLECT);
            mem_we_reg   <= (state_next == ST_WRITE);
            busy_reg     <= (state_next == ST_COLLECT) || (state_next == ST_WRITE);
            cpu_hold_reg <= (state_next == ST_COLLECT) || (state_next == ST_WRITE);
            done_reg     <= (state_next == ST_DONE);

            if (load_start) begin
                word_idx_reg <= '0;
                word_cnt_reg <= '0;
            end else if (state_reg == ST_WRITE) begin
                // The write strobe was already on the bus this cycle, so it counts even under abort.
                word_cnt_reg <= word_cnt_reg + 9'd1;
                if (!last_word && !abort) word_idx_reg <= word_idx_reg + IDX_W'(1);
            end

            if (word_full) begin
                mem_addr_reg  <= ADDR_W'(word_to_byte_addr(32'(word_idx_reg)));
                mem_wdata_reg <= DATA_W'(word_next);
            end
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign cpu_hold      = cpu_hold_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign word_cnt      = word_cnt_reg;

endmodule
